// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-way round-robin/fixed-priority selector feeding a one-entry registered valid/ready output stage.
module rr_mux_arb #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int RR    = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N-1:0]       REQ,
    input  logic [N*WIDTH-1:0] DIN,
    output logic [N-1:0]       ACK,
    input  logic               FORCE_EN,
    input  logic [SELW-1:0]    FORCE_SEL,
    output logic [WIDTH-1:0]   O,
    output logic [SELW-1:0]    OUT_SEL,
    output logic               OUT_VLD,
    input  logic               OUT_RDY
);
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] win;
    logic [N-1:0]    elig;
    logic            found;
    logic            xfer;
    int              idx;
    // ptr stays 0 in fixed-priority mode, so the rotating scan degenerates to lowest-index-first
    always_comb begin
        elig  = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        ACK   = '0;
        for (int i = 0; i < N; i++)
            elig[i] = REQ[i] & (!FORCE_EN | (int'(FORCE_SEL) == i));
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = SELW'(idx);
            end
        end
        xfer = RST_N & found & (!OUT_VLD | OUT_RDY);
        if (xfer)
            ACK[win] = 1'b1;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            O       <= '0;
            OUT_SEL <= '0;
            OUT_VLD <= 1'b0;
            ptr     <= '0;
        end else if (xfer) begin
            O       <= DIN[int'(win)*WIDTH +: WIDTH];
            OUT_SEL <= win;
            OUT_VLD <= 1'b1;
            ptr     <= (RR != 0 && int'(win) != N - 1) ? win + SELW'(1) : '0;
        end else if (OUT_RDY) begin
            OUT_VLD <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: four rr_mux_arb configurations share one stimulus stream and are checked against a per-instance reference model.
module tb_rr_mux_arb;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] din;
    logic        fen;
    logic [1:0]  fsel;
    logic        rdy;
    logic [3:0]  ack_v [4];
    logic [15:0] o_v [4];
    logic [1:0]  sel_v [4];
    logic        vld_v [4];
    logic [1:0]  a2;
    logic [2:0]  a3;
    logic        s2;
    int tests = 0;
    int fails = 0;
    int nn [4]  = '{4, 4, 2, 3};
    bit rrp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int          m_ptr [4];
    int          m_sel [4];
    logic [15:0] m_o [4];
    bit          m_vld [4];

    rr_mux_arb #(.WIDTH(16), .N(4), .SELW(2), .RR(1)) u_rr (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .DIN(din), .ACK(ack_v[0]),
        .FORCE_EN(fen), .FORCE_SEL(fsel), .O(o_v[0]), .OUT_SEL(sel_v[0]),
        .OUT_VLD(vld_v[0]), .OUT_RDY(rdy));
    rr_mux_arb #(.WIDTH(16), .N(4), .SELW(2), .RR(0)) u_fp (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .DIN(din), .ACK(ack_v[1]),
        .FORCE_EN(fen), .FORCE_SEL(fsel), .O(o_v[1]), .OUT_SEL(sel_v[1]),
        .OUT_VLD(vld_v[1]), .OUT_RDY(rdy));
    rr_mux_arb #(.WIDTH(16), .N(2), .SELW(1), .RR(0)) u_leg (
        .CLK(clk), .RST_N(rst_n), .REQ(req[1:0]), .DIN(din[31:0]), .ACK(a2),
        .FORCE_EN(fen), .FORCE_SEL(fsel[0:0]), .O(o_v[2]), .OUT_SEL(s2),
        .OUT_VLD(vld_v[2]), .OUT_RDY(rdy));
    rr_mux_arb #(.WIDTH(16), .N(3), .SELW(2), .RR(0)) u_n3 (
        .CLK(clk), .RST_N(rst_n), .REQ(req[2:0]), .DIN(din[47:0]), .ACK(a3),
        .FORCE_EN(fen), .FORCE_SEL(fsel), .O(o_v[3]), .OUT_SEL(sel_v[3]),
        .OUT_VLD(vld_v[3]), .OUT_RDY(rdy));

    assign ack_v[2] = {2'b00, a2};
    assign ack_v[3] = {1'b0, a3};
    assign sel_v[2] = {1'b0, s2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d]: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 4; k++) begin
            m_ptr[k] = 0;
            m_sel[k] = 0;
            m_o[k]   = 16'h0;
            m_vld[k] = 1'b0;
        end
    endtask

    // Scan channels starting at the model pointer; eligibility is the raw request filtered by the force rule.
    function automatic int winner(input int k);
        int fs = (k == 2) ? int'(fsel[0]) : int'(fsel);
        for (int s = 0; s < nn[k]; s++) begin
            int j = (m_ptr[k] + s) % nn[k];
            if (req[j] && (!fen || fs == j)) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        int w [4];
        bit go [4];
        #1;
        for (int k = 0; k < 4; k++) begin
            w[k]  = winner(k);
            go[k] = rst_n && w[k] >= 0 && (!m_vld[k] || rdy);
            chk("ack", k, 16'(ack_v[k]), go[k] ? 16'(1 << w[k]) : 16'h0);
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (go[k]) begin
                m_o[k]   = din[w[k]*16 +: 16];
                m_sel[k] = w[k];
                m_vld[k] = 1'b1;
                if (rrp[k]) m_ptr[k] = (w[k] + 1) % nn[k];
            end else if (rst_n && rdy) begin
                m_vld[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("o", k, o_v[k], m_o[k]);
            chk("sel", k, 16'(sel_v[k]), 16'(m_sel[k]));
            chk("vld", k, 16'(vld_v[k]), 16'(m_vld[k]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mreset();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        mreset();
        req  = 4'hF;
        din  = {$urandom, $urandom};
        fen  = 1'b0;
        fsel = 2'd0;
        rdy  = 1'b1;
        tick();
        tick();
        chk("rst_o", 0, o_v[0], 16'h0);
        chk("rst_vld", 0, 16'(vld_v[0]), 16'h0);
        chk("rst_ack", 0, 16'(ack_v[0]), 16'h0);
        rst_n = 1'b1;
        req   = 4'h0;
        tick();
        tick();
        chk("idle_vld", 0, 16'(vld_v[0]), 16'h0);

        fen = 1'b1;
        req = 4'hF;
        din = {32'h0, 16'hB0B0, 16'hAAAA};
        fsel = 2'd1;
        tick();
        chk("leg_o", 2, o_v[2], 16'hB0B0);
        chk("leg_sel", 2, 16'(sel_v[2]), 16'h1);
        fsel = 2'd0;
        tick();
        chk("leg_o", 2, o_v[2], 16'hAAAA);
        chk("leg_sel", 2, 16'(sel_v[2]), 16'h0);
        din  = {32'h0, 16'hFFFF, 16'h0000};
        fsel = 2'd1;
        tick();
        chk("leg_o", 2, o_v[2], 16'hFFFF);
        fsel = 2'd0;
        tick();
        chk("leg_o", 2, o_v[2], 16'h0000);

        do_reset();
        fen = 1'b0;
        req = 4'hF;
        din = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_sel", 0, 16'(sel_v[0]), 16'(i % 4));
            chk("rr_o", 0, o_v[0], 16'(16'h1000 + i % 4));
            chk("rr_vld", 0, 16'(vld_v[0]), 16'h1);
        end

        do_reset();
        tick();
        chk("bp_first", 0, o_v[0], 16'h1000);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ack", 0, 16'(ack_v[0]), 16'h0);
            chk("bp_hold", 0, o_v[0], 16'h1000);
        end
        rdy = 1'b1;
        #1;
        chk("bp_release_ack", 0, 16'(ack_v[0]), 16'h2);
        tick();
        chk("bp_next", 0, o_v[0], 16'h1001);

        req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fp_sel", 1, 16'(sel_v[1]), 16'h1);
        end
        fen  = 1'b1;
        fsel = 2'd3;
        tick();
        chk("force_sel", 1, 16'(sel_v[1]), 16'h3);
        chk("n3_vld", 3, 16'(vld_v[3]), 16'h0);
        tick();
        chk("n3_ack", 3, 16'(ack_v[3]), 16'h0);
        chk("n3_vld", 3, 16'(vld_v[3]), 16'h0);

        for (int i = 0; i < 400; i++) begin
            req  = 4'($urandom);
            din  = {$urandom, $urandom};
            fen  = ($urandom_range(0, 3) == 0);
            fsel = 2'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            tick();
        end

        do_reset();
        fen = 1'b0;
        req = 4'hF;
        rdy = 1'b1;
        din = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        tick();
        tick();
        tick();
        chk("mid_o", 0, o_v[0], 16'h1002);
        chk("mid_vld", 0, 16'(vld_v[0]), 16'h1);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("async_o", k, o_v[k], 16'h0);
            chk("async_vld", k, 16'(vld_v[k]), 16'h0);
            chk("async_ack", k, 16'(ack_v[k]), 16'h0);
        end
        mreset();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_sel", 0, 16'(sel_v[0]), 16'h0);
        chk("post_o", 0, o_v[0], 16'h1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
Parametrised N-way, WIDTH-bit registered operand/bus selector with handshake; successor to the fixed 16-bit 2:1 combinational mux.
- Arbitrates among N requesting sources, round-robin or fixed-priority, with an optional forced select that mirrors the legacy S input.
- Delivers the winner through a one-entry registered output stage with valid/ready back-pressure.
- Sits between the register-file/immediate/ALU-result producers and downstream consumers (ALU operand latch, memory write port).

Parameters:
WIDTH, 16, data width of each channel and of O
N, 4, number of input channels (2..16)
SELW, 2, index width; must equal ceil(log2(N)), minimum 1
RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous, active-low reset
REQ  input  N  per-channel request; bit i = channel i has a word
DIN  input  N*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH]
ACK  output  N  per-channel accept, combinational, one-hot or zero
FORCE_EN  input  1  1 = only channel FORCE_SEL is eligible
FORCE_SEL  input  SELW  forced channel index
O  output  WIDTH  registered selected data
OUT_SEL  output  SELW  registered index of the channel that supplied O
OUT_VLD  output  1  O/OUT_SEL hold a valid word
OUT_RDY  input  1  consumer accepts the word when OUT_VLD & OUT_RDY

Behaviour:
- Interface: one clock, CLK; reset asynchronous and active-low, RST_N. While RST_N=0: O=0, OUT_SEL=0, OUT_VLD=0, priority pointer PTR=0. ACK=0 combinationally.
- Reset mid-operation discards any buffered word; no ACK is issued during reset.
- Eligible set E = REQ masked by FORCE: if FORCE_EN=1, E = REQ & (1<<FORCE_SEL). If FORCE_SEL >= N, E=0.
- Stage free condition: FREE = !OUT_VLD | OUT_RDY.
- Winner W:
  - RR=1: first set bit of E scanning PTR, PTR+1, …, N-1, 0, …, PTR-1.
  - RR=0: lowest set bit of E.
- ACK[W]=1 only when E!=0 and FREE=1; otherwise ACK=0. ACK depends only on REQ, FORCE_*, PTR, OUT_VLD and OUT_RDY. There is no combinational path from DIN.
- Transfer on channel i = REQ[i] & ACK[i] at a rising edge. Requesters hold REQ and DIN stable until ACKed; dropping REQ before ACK is allowed and simply withdraws the request.
- On transfer: O <= DIN[W], OUT_SEL <= W, OUT_VLD <= 1. If RR=1, PTR <= (W+1) mod N; if RR=0, PTR is unused and stays 0.
- On OUT_VLD & OUT_RDY with no new transfer: OUT_VLD <= 0. O and OUT_SEL keep their last value.
- Simultaneous drain and accept in one cycle is allowed. This gives full throughput: one word per cycle, latency 1 cycle from ACK edge to OUT_VLD.
- Stall: while OUT_VLD=1 and OUT_RDY=0, O, OUT_SEL and OUT_VLD hold and ACK=0.
- PTR does not move when no transfer occurs; a FORCE_EN transfer advances PTR like any other.
- N=2, RR=0, FORCE_EN=1, OUT_RDY=1 reproduces the legacy 2:1 mux with S=FORCE_SEL, registered by one cycle.

Test Plan:
- Reset/idle: RST_N=0 with REQ=4'b1111 and random DIN -> ACK=0, O=0, OUT_VLD=0, OUT_SEL=0. Release reset with REQ=0 -> OUT_VLD stays 0.
- Legacy mux check: N=2, WIDTH=16, RR=0, FORCE_EN=1, REQ=2'b11, DIN={16'hB0B0,16'hAAAA}, OUT_RDY=1.
  - FORCE_SEL=1 -> next cycle O=16'hB0B0, OUT_SEL=1.
  - FORCE_SEL=0 -> O=16'hAAAA, OUT_SEL=0.
  - Repeat with 16'hFFFF / 16'h0000.
- Round-robin fairness: N=4, RR=1, REQ=4'b1111 held, OUT_RDY=1, DIN[i]=16'h1000+i -> OUT_SEL sequence 0,1,2,3,0; O=16'h1000,16'h1001,… with OUT_VLD=1 every cycle.
- Back-pressure: OUT_RDY=0 after first word 16'h1000.
  - Expected: ACK=0, O held at 16'h1000 for 5 cycles, PTR unchanged.
  - Raise OUT_RDY -> channel 1 ACKed the same cycle, O=16'h1001 on the next edge.
- Fixed priority and force-out-of-range: RR=0, REQ=4'b1010 -> OUT_SEL=1 repeatedly. FORCE_EN=1, FORCE_SEL=3 -> OUT_SEL=3. N=3 with FORCE_SEL=3 -> ACK=0, OUT_VLD falls after drain.
- Reset mid-stream: assert RST_N=0 asynchronously mid-cycle while OUT_VLD=1 and O=16'h1002 -> OUT_VLD=0 and O=0 immediately, without waiting for CLK. After release, the first grant goes to channel 0.
